// File: rtl/cam_pattern_gen.sv
// rtl/cam_pattern_gen.sv - camera-side frame/test-pattern transmitter (pclk/href/vsync/data)
`timescale 1ns/1ps
module cam_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_BLANK  = 144,
    parameter int VS_LINES = 3,
    parameter int V_BACK   = 17,
    parameter int V_FRONT  = 10,
    parameter int PCLK_DIV = 2
) (
    input  logic        clk_fast,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    output logic        pclk,
    output logic        href,
    output logic        vsync,
    output logic [7:0]  data,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic        busy
);

    localparam int LINE = 2 * H_ACTIVE + H_BLANK;
    localparam logic [15:0] LINE_LAST = 16'(LINE - 1);
    localparam logic [15:0] HREF_LEN  = 16'(2 * H_ACTIVE);
    localparam logic [15:0] LAST_LINE = 16'(V_ACTIVE - 1);
    localparam logic [15:0] VS_LAST   = 16'(VS_LINES * LINE - 1);
    localparam logic [15:0] VB_LAST   = 16'(V_BACK * LINE - 1);
    localparam logic [15:0] VF_LAST   = 16'(V_FRONT * LINE - 1);
    localparam int DIV_W = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PCLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE, VSYNC, VBACK, ACTIVE, VFRONT, DONE
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic             div_wrap;
    logic             fall_tick;
    logic [1:0]       sel_q;
    logic [15:0]      ph_cnt;
    logic [15:0]      h_cnt;
    logic [15:0]      h_next;
    logic [15:0]      line_cnt;
    logic [7:0]       byte_cnt;

    assign div_wrap  = (div_cnt == DIV_LAST);
    assign fall_tick = div_wrap & pclk;
    assign h_next    = h_cnt + 16'd1;

    function automatic logic [7:0] pick_byte(input logic [1:0] sel, input logic [7:0] cnt,
                                             input logic [15:0] idx, input logic [15:0] line);
        case (sel)
            2'd0:    pick_byte = 8'hAA;
            2'd1:    pick_byte = cnt;
            2'd2:    pick_byte = idx[7:0];
            default: pick_byte = line[7:0];
        endcase
    endfunction

    always_ff @(posedge clk_fast or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            pclk    <= 1'b0;
        end else if (div_wrap) begin
            div_cnt <= '0;
            pclk    <= ~pclk;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk_fast or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            sel_q      <= 2'd0;
            ph_cnt     <= 16'd0;
            h_cnt      <= 16'd0;
            line_cnt   <= 16'd0;
            byte_cnt   <= 8'd0;
            href       <= 1'b0;
            vsync      <= 1'b0;
            data       <= 8'd0;
            frame_done <= 1'b0;
            frame_cnt  <= 16'd0;
            busy       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (fall_tick && enable) begin
                        sel_q    <= pattern_sel;
                        busy     <= 1'b1;
                        vsync    <= 1'b1;
                        ph_cnt   <= 16'd0;
                        byte_cnt <= 8'd0;
                        state    <= VSYNC;
                    end
                end
                VSYNC: begin
                    if (fall_tick) begin
                        // Arriving from DONE, vsync is still low: this tick opens the first period.
                        if (!vsync) begin
                            vsync  <= 1'b1;
                            ph_cnt <= 16'd0;
                        end else if (ph_cnt == VS_LAST) begin
                            vsync  <= 1'b0;
                            ph_cnt <= 16'd0;
                            if (V_BACK == 0) begin
                                state    <= ACTIVE;
                                h_cnt    <= 16'd0;
                                line_cnt <= 16'd0;
                                href     <= 1'b1;
                                data     <= pick_byte(sel_q, byte_cnt, 16'd0, 16'd0);
                                byte_cnt <= byte_cnt + 8'd1;
                            end else begin
                                state <= VBACK;
                            end
                        end else begin
                            ph_cnt <= ph_cnt + 16'd1;
                        end
                    end
                end
                VBACK: begin
                    if (fall_tick) begin
                        if (ph_cnt == VB_LAST) begin
                            ph_cnt   <= 16'd0;
                            state    <= ACTIVE;
                            h_cnt    <= 16'd0;
                            line_cnt <= 16'd0;
                            href     <= 1'b1;
                            data     <= pick_byte(sel_q, byte_cnt, 16'd0, 16'd0);
                            byte_cnt <= byte_cnt + 8'd1;
                        end else begin
                            ph_cnt <= ph_cnt + 16'd1;
                        end
                    end
                end
                ACTIVE: begin
                    if (fall_tick) begin
                        if (h_cnt == LINE_LAST) begin
                            if (line_cnt == LAST_LINE) begin
                                href   <= 1'b0;
                                data   <= 8'd0;
                                ph_cnt <= 16'd0;
                                if (V_FRONT == 0) begin
                                    state      <= DONE;
                                    frame_done <= 1'b1;
                                    frame_cnt  <= frame_cnt + 16'd1;
                                end else begin
                                    state <= VFRONT;
                                end
                            end else begin
                                line_cnt <= line_cnt + 16'd1;
                                h_cnt    <= 16'd0;
                                href     <= 1'b1;
                                data     <= pick_byte(sel_q, byte_cnt, 16'd0, line_cnt + 16'd1);
                                byte_cnt <= byte_cnt + 8'd1;
                            end
                        end else begin
                            h_cnt <= h_next;
                            if (h_next < HREF_LEN) begin
                                href     <= 1'b1;
                                data     <= pick_byte(sel_q, byte_cnt, h_next, line_cnt);
                                byte_cnt <= byte_cnt + 8'd1;
                            end else begin
                                href <= 1'b0;
                                data <= 8'd0;
                            end
                        end
                    end
                end
                VFRONT: begin
                    if (fall_tick) begin
                        if (ph_cnt == VF_LAST) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                            frame_cnt  <= frame_cnt + 16'd1;
                        end else begin
                            ph_cnt <= ph_cnt + 16'd1;
                        end
                    end
                end
                DONE: begin
                    if (enable) begin
                        sel_q    <= pattern_sel;
                        byte_cnt <= 8'd0;
                        ph_cnt   <= 16'd0;
                        state    <= VSYNC;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_pattern_gen.sv
// tb/tb_cam_pattern_gen.sv - randomized self-checking bench for cam_pattern_gen
`timescale 1ns/1ps
module tb_cam_pattern_gen;

    logic clk_fast = 1'b0;
    logic reset_n;
    logic en_a, en_b;
    logic [1:0] pattern_sel;

    logic pclk_a, href_a, vsync_a, frame_done_a, busy_a;
    logic [7:0] data_a;
    logic [15:0] frame_cnt_a;
    logic pclk_b, href_b, vsync_b, frame_done_b, busy_b;
    logic [7:0] data_b;
    logic [15:0] frame_cnt_b;

    bit which;
    logic m_pclk, m_href, m_vsync, m_frame_done, m_busy;
    logic [7:0] m_data;
    logic [15:0] m_frame_cnt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk_fast = ~clk_fast;

    cam_pattern_gen #(.H_ACTIVE(4), .V_ACTIVE(3), .H_BLANK(2), .VS_LINES(1),
                      .V_BACK(1), .V_FRONT(1), .PCLK_DIV(1)) u_a (
        .clk_fast(clk_fast), .reset_n(reset_n), .enable(en_a), .pattern_sel(pattern_sel),
        .pclk(pclk_a), .href(href_a), .vsync(vsync_a), .data(data_a),
        .frame_done(frame_done_a), .frame_cnt(frame_cnt_a), .busy(busy_a));

    cam_pattern_gen #(.H_ACTIVE(100), .V_ACTIVE(3), .H_BLANK(2), .VS_LINES(1),
                      .V_BACK(0), .V_FRONT(0), .PCLK_DIV(3)) u_b (
        .clk_fast(clk_fast), .reset_n(reset_n), .enable(en_b), .pattern_sel(pattern_sel),
        .pclk(pclk_b), .href(href_b), .vsync(vsync_b), .data(data_b),
        .frame_done(frame_done_b), .frame_cnt(frame_cnt_b), .busy(busy_b));

    assign m_pclk       = which ? pclk_b       : pclk_a;
    assign m_href       = which ? href_b       : href_a;
    assign m_vsync      = which ? vsync_b      : vsync_a;
    assign m_data       = which ? data_b       : data_a;
    assign m_frame_done = which ? frame_done_b : frame_done_a;
    assign m_frame_cnt  = which ? frame_cnt_b  : frame_cnt_a;
    assign m_busy       = which ? busy_b       : busy_a;

    function automatic int g_ha(input bit w);  return w ? 100 : 4; endfunction
    function automatic int g_va(input bit w);  return 3;           endfunction
    function automatic int g_hb(input bit w);  return 2;           endfunction
    function automatic int g_vs(input bit w);  return 1;           endfunction
    function automatic int g_vb(input bit w);  return w ? 0 : 1;   endfunction
    function automatic int g_vf(input bit w);  return w ? 0 : 1;   endfunction
    function automatic int g_div(input bit w); return w ? 3 : 1;   endfunction
    function automatic int g_line(input bit w); return 2 * g_ha(w) + g_hb(w); endfunction
    function automatic int g_flen(input bit w);
        return (g_vs(w) + g_vb(w) + g_va(w) + g_vf(w)) * g_line(w);
    endfunction

    // Expected {vsync, href, data} for pclk period k of a frame.
    function automatic logic [9:0] model(input bit w, input logic [1:0] s, input int k);
        int line, vsl, vbl, al, a, ln, idx;
        logic [7:0] d;
        line = g_line(w);
        vsl  = g_vs(w) * line;
        vbl  = g_vb(w) * line;
        al   = g_va(w) * line;
        if (k < vsl) return 10'h200;
        if (k < vsl + vbl || k >= vsl + vbl + al) return 10'h000;
        a   = k - vsl - vbl;
        ln  = a / line;
        idx = a % line;
        if (idx >= 2 * g_ha(w)) return 10'h000;
        case (s)
            2'd0:    d = 8'hAA;
            2'd1:    d = 8'((ln * 2 * g_ha(w) + idx) % 256);
            2'd2:    d = 8'(idx % 256);
            default: d = 8'(ln % 256);
        endcase
        return {2'b01, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_en(input bit w, input logic v);
        if (w) en_b = v; else en_a = v;
    endtask

    task automatic run_frame(input bit w, input logic [1:0] fsel, input logic [1:0] nsel,
                             input bit drop, input logic [15:0] exp_cnt);
        int fl, dk, n;
        bit found;
        fl = g_flen(w);
        dk = (g_vs(w) + g_vb(w) + 1) * g_line(w) + 3;
        found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            @(posedge m_pclk);
            if (m_vsync === 1'b1) found = 1'b1;
        end
        chk($sformatf("frame_start_%0d", w), 32'(found), 32'd1);
        if (!found) return;
        for (int k = 0; k < fl; k++) begin
            if (k > 0) @(posedge m_pclk);
            chk($sformatf("pix_%0d_k%0d", w, k), {22'd0, m_vsync, m_href, m_data}, {22'd0, model(w, fsel, k)});
            #1;
            if (k == fl / 2) pattern_sel = 2'($urandom);
            if (drop && k == dk) set_en(w, 1'b0);
            if (k == fl - 1) pattern_sel = nsel;
        end
        n = 0;
        found = 1'b0;
        while (!found && n < 4 * g_div(w) + 4) begin
            @(negedge clk_fast);
            n++;
            if (m_frame_done === 1'b1) found = 1'b1;
        end
        chk("frame_done_latency", 32'(n), 32'(g_div(w) + 1));
        @(negedge clk_fast);
        chk("frame_done_single", 32'(m_frame_done), 32'd0);
        chk("frame_cnt", 32'(m_frame_cnt), 32'(exp_cnt));
        chk("busy_after_done", 32'(m_busy), 32'(!drop));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] rs;
        int n_vs;
        bit found;
        time t0;

        reset_n = 1'b0;
        en_a = 1'b0;
        en_b = 1'b0;
        pattern_sel = 2'd0;
        which = 1'b0;
        #23;
        chk("reset_a", {4'd0, pclk_a, href_a, vsync_a, data_a, frame_done_a, frame_cnt_a, busy_a}, 32'd0);
        chk("reset_b", {4'd0, pclk_b, href_b, vsync_b, data_b, frame_done_b, frame_cnt_b, busy_b}, 32'd0);
        @(negedge clk_fast);
        reset_n = 1'b1;
        repeat (10) @(negedge clk_fast);
        chk("idle_vsync_a", 32'(vsync_a), 32'd0);
        chk("idle_busy_a", 32'(busy_a), 32'd0);

        // Instance A: all four patterns back to back, enable dropped in the last frame.
        which = 1'b0;
        pattern_sel = 2'd0;
        en_a = 1'b1;
        run_frame(1'b0, 2'd0, 2'd1, 1'b0, 16'd1);
        run_frame(1'b0, 2'd1, 2'd2, 1'b0, 16'd2);
        run_frame(1'b0, 2'd2, 2'd3, 1'b0, 16'd3);
        run_frame(1'b0, 2'd3, 2'd0, 1'b1, 16'd4);
        n_vs = 0;
        repeat (200) begin
            @(negedge clk_fast);
            if (vsync_a !== 1'b0) n_vs++;
        end
        chk("no_vsync_after_drop", 32'(n_vs), 32'd0);
        chk("idle_busy_after_drop", 32'(busy_a), 32'd0);

        // Asynchronous reset in the middle of an active line.
        rs = 2'($urandom);
        pattern_sel = rs;
        en_a = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk_fast);
            if (href_a === 1'b1) found = 1'b1;
        end
        chk("reach_active", 32'(found), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_a", {4'd0, pclk_a, href_a, vsync_a, data_a, frame_done_a, frame_cnt_a, busy_a}, 32'd0);
        #3;
        reset_n = 1'b1;
        @(posedge clk_fast);
        #1;
        chk("post_reset_edge1", {30'd0, pclk_a, vsync_a}, 32'b10);
        @(posedge clk_fast);
        #1;
        chk("post_reset_edge2", {30'd0, pclk_a, vsync_a}, 32'b01);
        run_frame(1'b0, rs, 2'd0, 1'b1, 16'd1);

        // Instance B: PCLK_DIV=3, zero back/front porch, three continuous frames.
        which = 1'b1;
        @(posedge pclk_b);
        t0 = $time;
        @(posedge pclk_b);
        chk("pclk_period_b", 32'($time - t0), 32'd60);
        rs = 2'($urandom);
        pattern_sel = 2'd1;
        en_b = 1'b1;
        run_frame(1'b1, 2'd1, 2'd1, 1'b0, 16'd1);
        run_frame(1'b1, 2'd1, rs, 1'b0, 16'd2);
        run_frame(1'b1, rs, 2'd0, 1'b1, 16'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cam_pattern_gen.md
Name: cam_pattern_gen

Overview:
Synthesizable camera-side transmitter that drives the pclk/href/vsync/data[7:0] capture interface of sram_center. It produces a full frame with programmable geometry and selectable test patterns. Used for on-board self-test of the capture, SRAM and FX2 path without the sensor fitted, and as a bit-accurate stimulus source in benches. Runs from clk_fast and derives pclk internally.

Parameters:
H_ACTIVE, 640, active pixels per line (2 bytes per pixel, so href is high for 2*H_ACTIVE pclk periods)
V_ACTIVE, 480, active lines per frame
H_BLANK, 144, pclk periods with href=0 after each active line
VS_LINES, 3, lines with vsync high
V_BACK, 17, blank lines after vsync falls, before the first active line
V_FRONT, 10, blank lines after the last active line
PCLK_DIV, 2, clk_fast cycles per pclk half-period (min 1)

Ports:
clk_fast  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  level; start and continue frames while high
pattern_sel  in  2  0=const 0xAA, 1=frame byte counter, 2=line byte index, 3=line number
pclk  out  1  generated pixel clock
href  out  1  line-valid
vsync  out  1  frame sync, active high
data  out  8  pixel byte; valid at pclk rising edge
frame_done  out  1  one clk_fast pulse at end of each frame
frame_cnt  out  16  completed frames, wraps at 0xFFFF
busy  out  1  high from frame start to frame_done

Behaviour:
- Reset: async on reset_n low. pclk, href, vsync, data, frame_done, frame_cnt, busy all 0; FSM returns to IDLE; all counters 0.
- pclk divider: a counter 0..PCLK_DIV-1 runs in every state, including IDLE. pclk toggles when the counter wraps. "fall tick" means the clk_fast cycle in which pclk goes 1->0.
- All changes to href, vsync and data occur only on fall ticks. The receiver samples on the pclk rising edge, so every output is stable for a full half-period before sampling.
- Line length: LINE = 2*H_ACTIVE + H_BLANK pclk periods. Blank lines count time the same way, with href=0.
- FSM states: IDLE, VSYNC, VBACK, ACTIVE, VFRONT, DONE.
- IDLE: if enable=1 at a fall tick, latch pattern_sel and go to VSYNC. busy=1 and vsync=1 from that same fall tick.
- VSYNC: vsync=1 for VS_LINES*LINE pclk periods, then go to VBACK with vsync=0.
- VBACK: V_BACK*LINE periods, then ACTIVE.
- ACTIVE: each line has href=1 for 2*H_ACTIVE periods, then href=0 for H_BLANK periods. After V_ACTIVE lines, go to VFRONT.
- VFRONT: V_FRONT*LINE periods, then DONE.
- DONE: lasts one clk_fast cycle. frame_done=1 and frame_cnt increments in that cycle. Go to VSYNC if enable=1 (relatch pattern_sel, busy stays 1); otherwise go to IDLE with busy=0.
- A parameter value of 0 for V_BACK, V_FRONT or H_BLANK skips that phase or segment with no extra cycles. VS_LINES=0 is illegal.
- Data patterns (latched select; data=0 whenever href=0):
  - 0: 0xAA.
  - 1: 8-bit counter. Cleared at frame start, increments per active byte, wraps 0xFF->0x00 and continues across lines.
  - 2: byte index within the line, bits [7:0]. Restarts at 0 each line; wraps at 256.
  - 3: active line number, bits [7:0], starting at 0.
- enable deasserted mid-frame: the current frame completes normally, then the FSM goes to IDLE.
- pattern_sel changing mid-frame has no effect until the next frame start.
- Counters are 16 bits; parameters must satisfy LINE*max(VS_LINES, V_BACK, V_FRONT) < 65536.

Test Plan:
- Geometry: H_ACTIVE=4, V_ACTIVE=3, H_BLANK=2, VS_LINES=1, V_BACK=1, V_FRONT=1, PCLK_DIV=1, enable=1, sel=0. Required: vsync high 10 pclk periods; 3 href pulses of 8 periods each, spaced by 2 low periods; 24 bytes of 0xAA sampled on pclk rise; frame_done pulse; frame_cnt=1. Frame length 60 pclk periods.
- Pattern 1 with H_ACTIVE=100, V_ACTIVE=3: the 600 sampled bytes are 0x00..0xFF, 0x00..0xFF, 0x00..0x57, continuous across lines. Next frame starts again at 0x00.
- Pattern 2 and pattern 3, same small geometry: each line reads 00..07. Line bytes read all 00, then all 01, then all 02. data=0 during href low.
- enable dropped during the second active line: that frame completes, frame_done fires, busy falls, frame_cnt=1, no further vsync.
- reset_n pulsed low mid-ACTIVE, asynchronously and off a clock edge: all outputs 0 immediately. After release with enable=1, a clean frame starts with a vsync rise on the first fall tick.
- Continuous enable for 3 frames with PCLK_DIV=3: pclk period is 6 clk_fast cycles; frame_cnt=3; a single clk_fast frame_done pulse per frame; busy never drops between frames.
